pll_sequencer: RTL

Power-up and recovery sequencer for the board PLL that derives the 12 MHz USB clock from the 48 MHz oscillator. It runs on the raw oscillator clock and drives the PLL reset. It qualifies the asynchronous `locked` flag with a synchronizer, a stability window and a timeout with bounded retries. It then releases the reset of the USB/HID logic only after lock has been held stable.

---
 rtl/pll_seq_pkg.sv | 21 ++
 rtl/pll_sequencer_sync2.sv | 29 ++
 rtl/pll_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL power-up / recovery sequencer.
//   pll_seq_state_t : sequencer state encoding
//   cnt_width()     : width of a saturating counter that must reach the
//                     larger of two cycle limits
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLLRST,
    WAIT,
    RELEASE,
    RUN,
    FAIL
  } pll_seq_state_t;

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_sequencer_sync2.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Reused for any async flag entering the clk_i domain.
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset, clears both flops to 0
//   d_i   : asynchronous input
//   q_o   : synchronized output, 2 clk_i edges of latency
module sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_sequencer.sv
// Power-up and recovery sequencer for the board PLL (48 MHz osc -> 12 MHz).
// Holds the PLL in reset, waits for a stable synchronized lock within a
// timeout (with bounded retries), then releases the downstream reset.
//
// Ports:
//   clk     : 48 MHz oscillator clock (only clock)
//   reset   : asynchronous active-high, restarts the sequence
//   locked  : PLL lock flag, asynchronous to clk
//   pll_rst : high resets the PLL
//   sys_rst : active-high reset for downstream logic
//   ready   : high only while running with lock held
//   fail    : sticky, retries exhausted (cleared only by reset)
//   retries : PLL reset retries consumed in the current bring-up
//
// Build option:
//   PLL_SEQ_RELOCK_RST_EN : when defined, loss of lock while running
//   re-resets the PLL and repeats the full bring-up; otherwise the
//   sequencer only returns to waiting for stable lock.
module pll_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES     = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int RELEASE_CYCLES = 16,
  parameter int MAX_RETRY      = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           locked,
  output logic                           pll_rst,
  output logic                           sys_rst,
  output logic                           ready,
  output logic                           fail,
  output logic [$clog2(MAX_RETRY+1)-1:0] retries
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES, STABLE_CYCLES);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] RST_N     = CNT_W'(RST_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_N  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_N = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] RELEASE_N = CNT_W'(RELEASE_CYCLES);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  pll_seq_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] stab_q, stab_d, stab_inc;
  logic [RTY_W-1:0] retries_q, retries_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;
  logic             locked_s;

  sync2 u_lock_sync (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (locked),
    .q_o   (locked_s)
  );

  assign cnt_inc  = sat_inc(cnt_q);
  assign stab_inc = sat_inc(stab_q);

  // cnt_q is the phase timer: reset hold in PLLRST, timeout in WAIT and
  // hold-off in RELEASE. stab_q counts consecutive locked cycles in WAIT.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stab_d    = stab_q;
    retries_d = retries_q;

    case (state_q)
      PLLRST: begin
        cnt_d = cnt_inc;
        if (cnt_inc == RST_N) begin
          state_d = WAIT;
          cnt_d   = '0;
          stab_d  = '0;
        end
      end

      WAIT: begin
        cnt_d  = cnt_inc;
        stab_d = locked_s ? stab_inc : '0;
        // Stable completion is tested first so it beats a coincident timeout.
        if (locked_s && (stab_inc == STABLE_N)) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else if (cnt_inc == TIMEOUT_N) begin
          if (retries_q == RTY_MAX) begin
            state_d = FAIL;
          end else begin
            state_d   = PLLRST;
            retries_d = retries_q + 1'b1;
            cnt_d     = '0;
          end
        end
      end

      RELEASE: begin
        // Losing lock here only restarts qualification; it is not a retry.
        if (!locked_s) begin
          state_d = WAIT;
          cnt_d   = '0;
          stab_d  = '0;
        end else if (cnt_q == RELEASE_N) begin
          state_d   = RUN;
          retries_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      RUN: begin
        if (!locked_s) begin
`ifdef PLL_SEQ_RELOCK_RST_EN
          state_d   = PLLRST;
          retries_d = '0;
`else
          state_d   = WAIT;
`endif
          cnt_d  = '0;
          stab_d = '0;
        end
      end

      FAIL: begin
        state_d = FAIL;
      end

      default: begin
        state_d = PLLRST;
        cnt_d   = '0;
        stab_d  = '0;
      end
    endcase

    // Outputs are decoded from the next state so they register in step
    // with the state itself.
    pll_rst_d = (state_d == PLLRST);
    sys_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
    fail_d    = (state_d == FAIL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= PLLRST;
      cnt_q     <= '0;
      stab_q    <= '0;
      retries_q <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stab_q    <= stab_d;
      retries_q <= retries_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  assign pll_rst = pll_rst_q;
  assign sys_rst = sys_rst_q;
  assign ready   = ready_q;
  assign fail    = fail_q;
  assign retries = retries_q;

endmodule
